// File: rtl/ball_serve.sv
// rtl/ball_serve.sv - pong serve controller: frame delay, random serve draw, valid/ready offer
module ball_serve #(
  parameter int RND_NUM_W   = 16,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int MARGIN      = 16,
  parameter int SERVE_DELAY = 60
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [RND_NUM_W-1:0]         rnd_num_i,
  input  logic                         frame_tick_i,
  input  logic                         start_i,
  input  logic                         goal_left_i,
  input  logic                         goal_right_i,
  output logic                         serve_valid_o,
  input  logic                         serve_ready_i,
  output logic [$clog2(SCREEN_H)-1:0]  ball_y_o,
  output logic                         dir_x_o,
  output logic                         dir_y_o,
  output logic [1:0]                   speed_y_o,
  output logic                         in_play_o
);

  localparam int Y_W     = $clog2(SCREEN_H);
  localparam int Y_RANGE = SCREEN_H - BALL_SIZE - 2 * MARGIN;
  localparam int CNT_W   = $clog2(SERVE_DELAY + 1);

  localparam logic [Y_W-1:0]   Y_RANGE_V = Y_W'(Y_RANGE);
  localparam logic [Y_W-1:0]   MARGIN_V  = Y_W'(MARGIN);
  localparam logic [Y_W-1:0]   Y_RESET_V = Y_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [CNT_W-1:0] DELAY_V   = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_DRAW,
    S_OFFER,
    S_PLAY
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [Y_W-1:0]   y_q;
  logic [3:0]       r_hi_q;        // r[Y_W+3:Y_W]: dir_x, speed[1:0], dir_y
  logic             from_start_q;  // current serve follows start_i, not a goal
  logic             pend_dir_x_q;  // dir_x chosen by the last goal

  logic             tick_done;
  logic             y_big;
  logic             goal_any;
  logic             accept;
  logic [1:0]       speed_raw;

  // Only the low Y_W+4 random bits shape a serve; the rest are deliberately dropped.
  if (RND_NUM_W > Y_W + 4) begin : g_rnd_spare
    logic unused_rnd_hi;
    assign unused_rnd_hi = ^rnd_num_i[RND_NUM_W-1:Y_W+4];
  end

  assign tick_done = frame_tick_i && ((cnt_q + CNT_ONE) == DELAY_V);
  assign y_big     = (y_q >= Y_RANGE_V);
  assign goal_any  = goal_left_i | goal_right_i;
  assign accept    = serve_valid_o & serve_ready_i;
  assign speed_raw = r_hi_q[2:1];

  // State register with asynchronous reset back to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; inputs not relevant to the current state are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)   state_d = S_DELAY;
      S_DELAY: if (tick_done) state_d = S_DRAW;
      S_DRAW:  if (!y_big)    state_d = S_OFFER;
      S_OFFER: if (accept)    state_d = S_PLAY;
      S_PLAY:  if (goal_any)  state_d = S_DELAY;
      default:                state_d = S_IDLE;
    endcase
  end

  // Datapath: frame counter, random capture, range fold and registered serve outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      y_q           <= '0;
      r_hi_q        <= '0;
      from_start_q  <= 1'b1;
      pend_dir_x_q  <= 1'b1;
      serve_valid_o <= 1'b0;
      in_play_o     <= 1'b0;
      ball_y_o      <= Y_RESET_V;
      dir_x_o       <= 1'b1;
      dir_y_o       <= 1'b0;
      speed_y_o     <= 2'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q        <= '0;
            from_start_q <= 1'b1;
          end
        end
        S_DELAY: begin
          if (frame_tick_i) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (tick_done) begin
              y_q    <= rnd_num_i[Y_W-1:0];
              r_hi_q <= rnd_num_i[Y_W+3:Y_W];
            end
          end
        end
        S_DRAW: begin
          // One subtraction per cycle keeps the fold cheap; at most one is needed at defaults.
          if (y_big) begin
            y_q <= y_q - Y_RANGE_V;
          end else begin
            ball_y_o  <= MARGIN_V + y_q;
            dir_y_o   <= r_hi_q[0];
            speed_y_o <= (speed_raw == 2'd0) ? 2'd1 : speed_raw;
            dir_x_o   <= from_start_q ? r_hi_q[3] : pend_dir_x_q;
          end
        end
        S_OFFER: begin
          // Valid rises one cycle after the outputs load, then holds until accepted.
          if (accept) begin
            serve_valid_o <= 1'b0;
            in_play_o     <= 1'b1;
          end else begin
            serve_valid_o <= 1'b1;
          end
        end
        S_PLAY: begin
          if (goal_any) begin
            in_play_o    <= 1'b0;
            cnt_q        <= '0;
            from_start_q <= 1'b0;
            // Serve heads toward the side that conceded; left wins a tie.
            pend_dir_x_q <= ~goal_left_i;
          end
        end
        default: begin
          serve_valid_o <= 1'b0;
          in_play_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_serve.sv
// tb/tb_ball_serve.sv - scoreboard bench for ball_serve
module tb_ball_serve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] rnd = 16'h0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        goal_left = 1'b0;
  logic        goal_right = 1'b0;
  logic        serve_ready = 1'b0;
  logic        serve_valid;
  logic [8:0]  ball_y;
  logic        dir_x;
  logic        dir_y;
  logic [1:0]  speed_y;
  logic        in_play;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  typedef struct {
    int ball_y;
    int dir_y;
    int speed;
    int dir_x;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  ball_serve #(
    .RND_NUM_W  (16),
    .SCREEN_H   (480),
    .BALL_SIZE  (8),
    .MARGIN     (16),
    .SERVE_DELAY(2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rnd_num_i    (rnd),
    .frame_tick_i (frame_tick),
    .start_i      (start),
    .goal_left_i  (goal_left),
    .goal_right_i (goal_right),
    .serve_valid_o(serve_valid),
    .serve_ready_i(serve_ready),
    .ball_y_o     (ball_y),
    .dir_x_o      (dir_x),
    .dir_y_o      (dir_y),
    .speed_y_o    (speed_y),
    .in_play_o    (in_play)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every new serve offer is matched against the oldest expectation.
  always @(negedge clk) begin
    if (serve_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_serve", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("serve_ball_y", int'(ball_y), e.ball_y);
        check("serve_dir_y", int'(dir_y), e.dir_y);
        check("serve_speed_y", int'(speed_y), e.speed);
        check("serve_dir_x", int'(dir_x), e.dir_x);
        check("serve_latency", cyc, e.cyc);
      end
    end
    prev_valid = serve_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rnd = 16'($urandom);
    end
  endtask

  task automatic tick_with(input logic [15:0] rv, output int tc);
    @(posedge clk); #1;
    frame_tick = 1'b1;
    rnd = rv;
    @(posedge clk); #1;
    tc = cyc;
    frame_tick = 1'b0;
    rnd = 16'($urandom);
  endtask

  task automatic start_game();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    step(2);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!serve_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("serve_valid_seen", int'(serve_valid), 1);
  endtask

  task automatic serve(input logic [15:0] rv, input int by, input int dy,
                       input int sp, input int dx, input int k);
    int tc;
    exp_t e;
    tick_with(16'($urandom), tc);
    step(2);
    tick_with(rv, tc);
    e.ball_y = by; e.dir_y = dy; e.speed = sp; e.dir_x = dx; e.cyc = tc + 2 + k;
    exp_q.push_back(e);
    wait_valid();
  endtask

  task automatic handshake();
    @(posedge clk); #1 serve_ready = 1'b1;
    @(posedge clk); #1 serve_ready = 1'b0;
    check("hs_valid_low", int'(serve_valid), 0);
    check("hs_in_play", int'(in_play), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, int'(serve_valid), 0);
    check({tag, "_in_play"}, int'(in_play), 0);
    check({tag, "_ball_y"}, int'(ball_y), 236);
    check({tag, "_dir_x"}, int'(dir_x), 1);
    check({tag, "_dir_y"}, int'(dir_y), 0);
    check({tag, "_speed_y"}, int'(speed_y), 1);
  endtask

  task automatic idle_no_start(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rnd = 16'($urandom);
      frame_tick = (i % 3 == 0);
      goal_left = (i % 11 == 5);
      goal_right = (i % 13 == 7);
    end
    @(posedge clk); #1;
    frame_tick = 1'b0; goal_left = 1'b0; goal_right = 1'b0;
    check("idle_valid", int'(serve_valid), 0);
    check("idle_in_play", int'(in_play), 0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    // Reset state held for 1000 cycles with no start; ticks and goals must be ignored.
    idle_no_start(1000);
    @(negedge clk);
    check_reset_vals("reset");

    // Start serve: 0x0ABC -> y 188, no fold.
    start_game();
    serve(16'h0ABC, 204, 1, 2, 0, 0);

    // Offer must hold steady while ready is low and other inputs churn.
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      rnd = 16'($urandom);
      frame_tick = (i % 5 == 0);
      goal_left = (i == 10);
      goal_right = (i == 20);
      start = (i == 30);
      @(negedge clk);
      check("offer_ball_y", int'(ball_y), 204);
      check("offer_flags", int'({serve_valid, in_play, dir_x, dir_y, speed_y}), 6'b10_0_1_10);
    end
    @(posedge clk); #1;
    frame_tick = 1'b0; goal_left = 1'b0; goal_right = 1'b0; start = 1'b0;
    handshake();

    // Simultaneous goals: left wins, so the goal-driven dir_x of 0 beats rnd bit 12.
    step(3);
    @(posedge clk); #1 goal_left = 1'b1; goal_right = 1'b1;
    @(posedge clk); #1 goal_left = 1'b0; goal_right = 1'b0;
    check("goal_in_play_low", int'(in_play), 0);
    @(posedge clk); #1 goal_right = 1'b1;
    @(posedge clk); #1 goal_right = 1'b0;
    serve(16'h11F0, 72, 0, 1, 0, 1);
    @(posedge clk); #1 goal_right = 1'b1;
    @(posedge clk); #1 goal_right = 1'b0;
    @(negedge clk);
    check("offer_goal_ignored", int'(serve_valid), 1);
    handshake();

    // Right goal sends the serve right; ready held high early must not pre-empt valid.
    step(2);
    @(posedge clk); #1 goal_right = 1'b1;
    @(posedge clk); #1 goal_right = 1'b0; serve_ready = 1'b1;
    serve(16'h0ABC, 204, 1, 2, 1, 0);
    @(posedge clk); #1 serve_ready = 1'b0;
    check("early_ready_valid", int'(serve_valid), 0);
    check("early_ready_in_play", int'(in_play), 1);

    // Reset in DELAY, then a start is needed before any serve.
    @(posedge clk); #1 goal_left = 1'b1;
    @(posedge clk); #1 goal_left = 1'b0;
    step(2);
    async_reset("rst_delay");
    idle_no_start(12);

    // Start serve with fold: 0x01F0 -> 496 - 440 = 56.
    start_game();
    serve(16'h01F0, 72, 0, 1, 0, 1);
    async_reset("rst_offer");
    idle_no_start(12);

    // All-ones field: 511 -> 71, speed 3, dir_x from bit 12.
    start_game();
    serve(16'h3FFF, 87, 1, 3, 1, 1);
    handshake();

    step(4);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
